// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, destination select and branch resolution,
// registered into the EX/MEM pipeline register with stall/flush control.
module execute_stage #(
    parameter int ADDR_BITS      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int EXEC_BUS_WIDTH = 6,
    parameter int MEM_BUS_WIDTH  = 3,
    parameter int WB_BUS_WIDTH   = 2,
    parameter int REG_ADDR_BITS  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic [EXEC_BUS_WIDTH-1:0] execute_bus_in,
    input  logic [MEM_BUS_WIDTH-1:0]  memory_bus_in,
    input  logic [WB_BUS_WIDTH-1:0]   wb_bus_in,
    input  logic [ADDR_BITS-1:0]      next_pc_in,
    input  logic [DATA_WIDTH-1:0]     reg_rs_data_in,
    input  logic [DATA_WIDTH-1:0]     reg_rt_data_in,
    input  logic [DATA_WIDTH-1:0]     inm_data_in,
    input  logic [REG_ADDR_BITS-1:0]  add_reg_rt_in,
    input  logic [REG_ADDR_BITS-1:0]  add_reg_rd_in,
    input  logic [1:0]                fwd_a_sel,
    input  logic [1:0]                fwd_b_sel,
    input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
    input  logic [DATA_WIDTH-1:0]     wb_fwd_data,
    output logic                      valid_out,
    output logic [MEM_BUS_WIDTH-1:0]  memory_bus_out,
    output logic [WB_BUS_WIDTH-1:0]   wb_bus_out,
    output logic [DATA_WIDTH-1:0]     alu_result_out,
    output logic [DATA_WIDTH-1:0]     store_data_out,
    output logic [REG_ADDR_BITS-1:0]  add_reg_w_out,
    output logic [ADDR_BITS-1:0]      branch_target_out,
    output logic                      branch_taken_out,
    output logic                      overflow_out
);
    localparam int MSB = DATA_WIDTH - 1;

    typedef struct packed {
        logic                     valid;
        logic [MEM_BUS_WIDTH-1:0] mem_bus;
        logic [WB_BUS_WIDTH-1:0]  wb_bus;
        logic [DATA_WIDTH-1:0]    alu;
        logic [DATA_WIDTH-1:0]    store;
        logic [REG_ADDR_BITS-1:0] wreg;
        logic [ADDR_BITS-1:0]     target;
        logic                     taken;
        logic                     ovf;
    } exmem_t;

    exmem_t exmem_d, exmem_q;

    logic [3:0]            alu_op;
    logic                  alu_src, reg_dst, zero;
    logic [DATA_WIDTH-1:0] op_a, fwd_b, op_b, sum, diff, alu_res, inm_shl;
    logic                  ovf;

    assign alu_op  = execute_bus_in[3:0];
    assign alu_src = execute_bus_in[4];
    assign reg_dst = execute_bus_in[5];

    always_comb begin
        case (fwd_a_sel)
            2'b01:   op_a = mem_fwd_data;
            2'b10:   op_a = wb_fwd_data;
            default: op_a = reg_rs_data_in;
        endcase
        case (fwd_b_sel)
            2'b01:   fwd_b = mem_fwd_data;
            2'b10:   fwd_b = wb_fwd_data;
            default: fwd_b = reg_rt_data_in;
        endcase
    end

    assign op_b = alu_src ? inm_data_in : fwd_b;
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;
    // Branch compare uses the forwarded rt value, never the immediate.
    assign zero = (op_a == fwd_b);
    assign inm_shl = inm_data_in << 2;

    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (alu_op)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: begin
                alu_res = sum;
                ovf     = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            4'b0011: alu_res = op_a ^ op_b;
            4'b0110: begin
                alu_res = diff;
                ovf     = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            4'b0111: alu_res = DATA_WIDTH'($signed(op_a) < $signed(op_b));
            4'b1100: alu_res = ~(op_a | op_b);
            4'b0101: alu_res = {{(DATA_WIDTH-16){1'b0}}, op_b[15:0]} << 16;
            4'b1000: alu_res = DATA_WIDTH'(op_a < op_b);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        exmem_d         = '0;
        exmem_d.valid   = valid_in;
        exmem_d.mem_bus = valid_in ? memory_bus_in : '0;
        exmem_d.wb_bus  = valid_in ? wb_bus_in : '0;
        exmem_d.alu     = alu_res;
        exmem_d.store   = fwd_b;
        exmem_d.wreg    = reg_dst ? add_reg_rd_in : add_reg_rt_in;
        exmem_d.target  = next_pc_in + ADDR_BITS'(inm_shl);
        exmem_d.taken   = memory_bus_in[2] & zero & valid_in;
        exmem_d.ovf     = ovf & valid_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      exmem_q <= '0;
        else if (flush)  exmem_q <= '0;
        else if (!stall) exmem_q <= exmem_d;
    end

    assign valid_out         = exmem_q.valid;
    assign memory_bus_out    = exmem_q.mem_bus;
    assign wb_bus_out        = exmem_q.wb_bus;
    assign alu_result_out    = exmem_q.alu;
    assign store_data_out    = exmem_q.store;
    assign add_reg_w_out     = exmem_q.wreg;
    assign branch_target_out = exmem_q.target;
    assign branch_taken_out  = exmem_q.taken;
    assign overflow_out      = exmem_q.ovf;
endmodule
